// File: rtl/thermostat_ctrl.sv
// thermostat_ctrl: hysteresis thermostat with min-on, min-off and fan purge.
// Define THERMO_FAULT_EN to add the run-time fault latch and fault port.
module thermostat_ctrl #(
  parameter int TW      = 8,
  parameter int HYST    = 2,
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 3,
  parameter int PURGE   = 2,
  parameter int MAX_RUN = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] temp,
  input  logic [TW-1:0] setpoint,
  input  logic          mode,
  input  logic          fan_on,
  output logic          heater,
  output logic          aircon,
  output logic          fan,
  output logic [1:0]    state
`ifdef THERMO_FAULT_EN
  ,
  output logic          fault
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAT = 2'd1,
    S_COOL = 2'd2,
    S_LOCK = 2'd3
  } st_e;

  localparam int M1 = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int M2 = (M1 > PURGE) ? M1 : PURGE;
  localparam int M3 = (M2 > MAX_RUN) ? M2 : MAX_RUN;
  localparam int CW = $clog2(M3 + 1);

  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] C_MIN_ON  = CW'(MIN_ON);
  localparam logic [CW-1:0] C_MIN_OFF = CW'(MIN_OFF);
  localparam logic [CW-1:0] C_PURGE   = CW'(PURGE);
  localparam logic [TW:0]   C_HYST    = (TW+1)'(HYST);

  st_e           r_st;
  st_e           w_nst;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] r_purge;
  logic [CW-1:0] w_npurge;
  logic          r_fan_req;

  logic [TW:0]   w_t;
  logic [TW:0]   w_sp;
  logic [TW:0]   w_tph;
  logic [TW:0]   w_sph;
  logic          w_heat_start;
  logic          w_heat_done;
  logic          w_cool_start;
  logic          w_cool_done;
  logic          w_done;
  logic          w_trip;
  logic          w_hold;

  logic          r_heater;
  logic          r_aircon;
  logic          r_fan;
  logic [1:0]    r_state;

  // one extra bit keeps the +HYST sums from wrapping
  assign w_t   = {1'b0, temp};
  assign w_sp  = {1'b0, setpoint};
  assign w_tph = w_t + C_HYST;
  assign w_sph = w_sp + C_HYST;

  assign w_heat_start = mode & (w_tph < w_sp);
  assign w_heat_done  = ~mode | (w_t >= w_sph);
  assign w_cool_start = ~mode & (w_t > w_sph);
  assign w_cool_done  = mode | (w_tph <= w_sp);

  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;

`ifdef THERMO_FAULT_EN
  localparam logic [CW-1:0] C_MAX_RUN = CW'(MAX_RUN);
  logic r_fault;
  logic r_fault_o;

  assign w_trip = (r_cnt >= C_MAX_RUN);
  assign w_hold = r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault   <= 1'b0;
      r_fault_o <= 1'b0;
    end else begin
      if ((r_st == S_HEAT || r_st == S_COOL) && w_trip)
        r_fault <= 1'b1;
      r_fault_o <= r_fault;
    end
  end

  assign fault = r_fault_o;
`else
  assign w_trip = 1'b0;
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= S_IDLE;
      r_cnt     <= '0;
      r_purge   <= '0;
      r_fan_req <= 1'b0;
    end else begin
      r_st      <= w_nst;
      r_cnt     <= w_ncnt;
      r_purge   <= w_npurge;
      r_fan_req <= fan_on;
    end
  end

  always_comb begin
    w_nst    = r_st;
    w_ncnt   = r_cnt;
    w_npurge = (r_purge != '0) ? r_purge - C_ONE : '0;
    w_done   = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (w_heat_start) begin
          w_nst  = S_HEAT;
          w_ncnt = C_ONE;
        end else if (w_cool_start) begin
          w_nst  = S_COOL;
          w_ncnt = C_ONE;
        end
      end
      S_HEAT, S_COOL: begin
        w_done = (r_st == S_HEAT) ? w_heat_done : w_cool_done;
        if (w_trip || (w_done && r_cnt >= C_MIN_ON)) begin
          w_nst    = S_LOCK;
          w_ncnt   = C_ONE;
          w_npurge = C_PURGE;
        end else begin
          w_ncnt = w_cnt_inc;
        end
      end
      S_LOCK: begin
        if (!w_hold && r_cnt >= C_MIN_OFF) begin
          w_nst  = S_IDLE;
          w_ncnt = '0;
        end else begin
          w_ncnt = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  // relay stage: outputs lag the FSM by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_heater <= 1'b0;
      r_aircon <= 1'b0;
      r_fan    <= 1'b0;
      r_state  <= 2'd0;
    end else begin
      r_heater <= (r_st == S_HEAT);
      r_aircon <= (r_st == S_COOL);
      r_fan    <= (r_st == S_HEAT) | (r_st == S_COOL)
                | r_fan_req | (r_purge != '0);
      r_state  <= r_st;
    end
  end

  assign heater = r_heater;
  assign aircon = r_aircon;
  assign fan    = r_fan;
  assign state  = r_state;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb_thermostat_ctrl: scoreboard bench for thermostat_ctrl.
// Behavioural model pushes expected outputs; tasks pop and compare.
module tb_thermostat_ctrl;

  localparam int HYST    = 2;
  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
  localparam int PURGE   = 2;
  localparam int MAX_RUN = 10;
`ifdef THERMO_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] temp     = 8'd100;
  logic [7:0] setpoint = 8'd100;
  logic       mode     = 1'b1;
  logic       fan_on   = 1'b0;
  logic       heater;
  logic       aircon;
  logic       fan;
  logic [1:0] state;
  logic       fault_w;

`ifdef THERMO_FAULT_EN
  logic fault;
  assign fault_w = fault;
`else
  assign fault_w = 1'b0;
`endif

  thermostat_ctrl #(
    .TW(8), .HYST(HYST), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
    .PURGE(PURGE), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .temp(temp),
    .setpoint(setpoint),
    .mode(mode),
    .fan_on(fan_on),
    .heater(heater),
    .aircon(aircon),
    .fan(fan),
    .state(state)
`ifdef THERMO_FAULT_EN
    ,
    .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st    = 0;
  int m_cnt   = 0;
  int m_purge = 0;
  bit m_freq  = 1'b0;
  bit m_fault = 1'b0;

  logic [5:0] sb[$];
  logic [5:0] e;

  function automatic logic [5:0] got();
    return {fault_w, heater, aircon, fan, state};
  endfunction

  // model: predicts outputs after this edge, then advances its FSM
  task automatic step();
    logic [5:0] x;
    bit hs, hd, cs, cd, dn;
    int t, s, np;
    if (reset) begin
      x = '0;
      m_st = 0; m_cnt = 0; m_purge = 0;
      m_freq = 1'b0; m_fault = 1'b0;
    end else begin
      x[5]   = m_fault;
      x[4]   = (m_st == 1);
      x[3]   = (m_st == 2);
      x[2]   = (m_st == 1) || (m_st == 2) || m_freq || (m_purge > 0);
      x[1:0] = 2'(m_st);
      t  = int'(temp);
      s  = int'(setpoint);
      hs = mode && (t + HYST < s);
      hd = !mode || (t >= s + HYST);
      cs = !mode && (t > s + HYST);
      cd = mode || (t + HYST <= s);
      np = (m_purge > 0) ? m_purge - 1 : 0;
      case (m_st)
        0: begin
          if (hs) begin m_st = 1; m_cnt = 1; end
          else if (cs) begin m_st = 2; m_cnt = 1; end
        end
        1, 2: begin
          dn = (m_st == 1) ? hd : cd;
          if (FEN && m_cnt >= MAX_RUN) begin
            m_st = 3; m_cnt = 1; np = PURGE; m_fault = 1'b1;
          end else if (dn && m_cnt >= MIN_ON) begin
            m_st = 3; m_cnt = 1; np = PURGE;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          if (!m_fault && m_cnt >= MIN_OFF) begin m_st = 0; m_cnt = 0; end
          else m_cnt++;
        end
      endcase
      m_purge = np;
      m_freq  = fan_on;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      reset  = 1'b1;
      temp   = 8'($urandom_range(0, 255));
      mode   = 1'($urandom_range(0, 1));
      fan_on = 1'($urandom_range(0, 1));
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, got(), e);
      end
    end
    n_cmp++;
    if (got() !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_zero got=%b exp=%b", got(), 6'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_heat();
    int tt[13] = '{0, 97, 97, 98, 98, 98, 98, 102, 102, 102, 102, 102, 102};
    setpoint = 8'd100; mode = 1'b1; fan_on = 1'b0;
    for (int i = 0; i < 13; i++) begin
      reset = (i == 0);
      temp  = 8'(tt[i]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL heat[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i == 2 || i == 8 || i == 10 || i == 11) begin
        n_cmp++;
        if ((i == 2  && {heater, fan} !== 2'b11) ||
            (i == 8  && {heater, fan} !== 2'b01) ||
            (i == 10 && {fan, state} !== 3'b011) ||
            (i == 11 && state !== 2'd0)) begin
          n_bad++;
          $display("FAIL heat_pt[%0d] got h=%b f=%b st=%0d", i, heater, fan, state);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int tt[9] = '{0, 98, 98, 98, 102, 102, 102, 103, 103};
    bit mm[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    setpoint = 8'd100; fan_on = 1'b0;
    for (int i = 0; i < 9; i++) begin
      reset = (i == 0);
      temp  = 8'(tt[i]);
      mode  = mm[i];
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL boundary[%0d] got=%b exp=%b", i, got(), e);
      end
    end
    n_cmp++;
    if ({heater, aircon, state} !== 4'b0110) begin
      n_bad++;
      $display("FAIL boundary_cool got h=%b a=%b st=%0d exp h=0 a=1 st=2",
               heater, aircon, state);
    end
  endtask

  task automatic test_min_on();
    int tt[8] = '{0, 103, 90, 90, 90, 90, 90, 90};
    int ac = 0;
    setpoint = 8'd100; mode = 1'b0; fan_on = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reset = (i == 0);
      temp  = 8'(tt[i]);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL min_on[%0d] got=%b exp=%b", i, got(), e);
      end
      if (aircon === 1'b1) ac++;
    end
    n_cmp++;
    if (ac != MIN_ON) begin
      n_bad++;
      $display("FAIL min_on_len got=%0d exp=%0d", ac, MIN_ON);
    end
  endtask

  task automatic test_lockout();
    int tt[12] = '{0, 103, 90, 90, 90, 97, 97, 97, 97, 97, 97, 97};
    bit mm[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    setpoint = 8'd100; fan_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      reset = (i == 0);
      temp  = 8'(tt[i]);
      mode  = mm[i];
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL lockout[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i >= 6 && i <= 8) begin
        n_cmp++;
        if ({heater, state} !== 3'b011) begin
          n_bad++;
          $display("FAIL lockout_hold[%0d] got h=%b st=%0d exp h=0 st=3",
                   i, heater, state);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (heater !== 1'b1) begin
          n_bad++;
          $display("FAIL lockout_restart got h=%b exp h=1", heater);
        end
      end
    end
  endtask

  task automatic test_mode_flip();
    setpoint = 8'd100; fan_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      reset = (i == 0);
      temp  = (i <= 1) ? 8'd97 : 8'd110;
      mode  = (i <= 1);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e || (heater & aircon) !== 1'b0) begin
        n_bad++;
        $display("FAIL mode_flip[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i == 5 || i == 6 || i == 10) begin
        n_cmp++;
        if ((i == 5  && heater !== 1'b1) ||
            (i == 6  && {heater, state} !== 3'b011) ||
            (i == 10 && aircon !== 1'b1)) begin
          n_bad++;
          $display("FAIL flip_pt[%0d] got h=%b a=%b st=%0d", i, heater, aircon, state);
        end
      end
    end
  endtask

  task automatic test_fan();
    setpoint = 8'd100; mode = 1'b1; temp = 8'd100;
    for (int i = 0; i < 7; i++) begin
      reset  = (i == 0);
      fan_on = (i >= 1 && i <= 3);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL fan[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i == 2 || i == 5) begin
        n_cmp++;
        if (fan !== (i == 2)) begin
          n_bad++;
          $display("FAIL fan_pt[%0d] got=%b exp=%b", i, fan, (i == 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    setpoint = 8'd100; mode = 1'b1; fan_on = 1'b0;
    for (int i = 0; i < 7; i++) begin
      reset = (i == 0 || i == 4);
      temp  = (i <= 4) ? 8'd97 : 8'd100;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL reset_mid[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i == 5) begin
        n_cmp++;
        if ({heater, fan, state} !== 4'b0) begin
          n_bad++;
          $display("FAIL reset_mid_off got h=%b f=%b st=%0d exp 0", heater, fan, state);
        end
      end
    end
  endtask

`ifdef THERMO_FAULT_EN
  task automatic test_fault();
    setpoint = 8'd100; mode = 1'b1; fan_on = 1'b0;
    for (int i = 0; i < 19; i++) begin
      reset = (i == 0 || i == 17);
      temp  = (i <= 16) ? 8'd90 : 8'd100;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL fault[%0d] got=%b exp=%b", i, got(), e);
      end
      if (i == 12 || i == 16 || i == 17) begin
        n_cmp++;
        if ((i == 12 && {fault, heater} !== 2'b10) ||
            (i == 16 && {fault, state} !== 3'b111) ||
            (i == 17 && fault !== 1'b0)) begin
          n_bad++;
          $display("FAIL fault_pt[%0d] got fl=%b h=%b st=%0d", i, fault, heater, state);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    setpoint = 8'd100;
    for (int i = 0; i < 120; i++) begin
      reset = (i == 0) || ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      temp   = 8'($urandom_range(88, 112));
      fan_on = ($urandom_range(0, 3) == 0);
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e || (heater & aircon) !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b[%0d] got=%b exp=%b", i, got(), e);
      end
    end
    temp = 8'd0; setpoint = 8'd255; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reset = (i == 0);
      if (i == 2) begin temp = 8'd255; setpoint = 8'd0; mode = 1'b0; end
      step();
      e = sb.pop_front();
      n_cmp++;
      if (got() !== e) begin
        n_bad++;
        $display("FAIL extreme[%0d] got=%b exp=%b", i, got(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_heat();
    test_boundary();
    test_min_on();
    test_lockout();
    test_mode_flip();
    test_fan();
    test_reset_mid();
`ifdef THERMO_FAULT_EN
    test_fault();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
